// File: rtl/aes_pkg.sv
// Shared AES constants and types.
//   AES_STATE_BYTES : bytes per AES state (16)
//   INV_SR_IDX      : source byte index for each InvShiftRows output byte k
//   SR_IDX          : source byte index for each ShiftRows output byte k
//   share_byte_t    : one 8-bit share of a state byte
package aes_pkg;

    localparam int unsigned AES_STATE_BYTES = 16;
    localparam int unsigned AES_IDX_W       = 4;

    typedef logic [7:0] share_byte_t;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } isr_state_e;

    // Byte index k = r + 4c; entry k = r + 4*((c - r) mod 4)
    localparam logic [AES_IDX_W-1:0] INV_SR_IDX [AES_STATE_BYTES] = '{
        4'd0,  4'd13, 4'd10, 4'd7,
        4'd4,  4'd1,  4'd14, 4'd11,
        4'd8,  4'd5,  4'd2,  4'd15,
        4'd12, 4'd9,  4'd6,  4'd3
    };

    // Byte index k = r + 4c; entry k = r + 4*((c + r) mod 4)
    localparam logic [AES_IDX_W-1:0] SR_IDX [AES_STATE_BYTES] = '{
        4'd0,  4'd5,  4'd10, 4'd15,
        4'd4,  4'd9,  4'd14, 4'd3,
        4'd8,  4'd13, 4'd2,  4'd7,
        4'd12, 4'd1,  4'd6,  4'd11
    };

endpackage

// File: rtl/aes_inv_shift_row_serial.sv
// Byte-serial, share-parallel InvShiftRows stage for masked AES decryption.
// Collects a 16-byte state in column-major order, then replays it permuted.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input byte valid
//   in_ready   : block accepts a byte (LOAD phase)
//   in_data    : 8*NUM_SHARES bits, share s at [8*s+7:8*s]
//   out_valid  : output byte valid (DRAIN phase)
//   out_ready  : downstream accepts the byte
//   out_data   : permuted byte, same share layout as in_data
//   out_last   : marks the 16th output byte
//   busy       : a block is partially loaded or being drained
module aes_inv_shift_row_serial
    import aes_pkg::*;
#(
    parameter int unsigned NUM_SHARES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*NUM_SHARES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*NUM_SHARES-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int unsigned DW = 8 * NUM_SHARES;

    isr_state_e           r_state;
    isr_state_e           w_state_nxt;
    logic [AES_IDX_W-1:0] r_cnt;
    logic [DW-1:0]        r_buf [AES_STATE_BYTES];

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_cnt_last;
    logic [AES_IDX_W-1:0] w_rd_idx;
    logic [DW-1:0]        w_rd_word;

    assign w_cnt_last = (r_cnt == AES_IDX_W'(AES_STATE_BYTES - 1));
    assign w_in_fire  = (r_state == ST_LOAD)  && in_valid;
    assign w_out_fire = (r_state == ST_DRAIN) && out_ready;
    assign w_rd_idx   = INV_SR_IDX[r_cnt];
    assign w_rd_word  = r_buf[w_rd_idx];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: phase flips on the 16th transfer of each phase
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:  if (w_in_fire  && w_cnt_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_fire && w_cnt_last) w_state_nxt = ST_LOAD;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    // Byte counter; the 4-bit wrap at 15 coincides with the phase change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_in_fire || w_out_fire) begin
            r_cnt <= r_cnt + AES_IDX_W'(1);
        end
    end

    // State buffer, cleared on reset so no stale shares survive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(AES_STATE_BYTES); i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_in_fire) begin
            r_buf[r_cnt] <= in_data;
        end
    end

    // Outputs decoded from registered state; each share sliced independently
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = (r_state != ST_LOAD) || (r_cnt != '0);
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_cnt_last;
                for (int unsigned s = 0; s < NUM_SHARES; s++) begin
                    out_data[8*s +: 8] = w_rd_word[8*s +: 8];
                end
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_inv_shift_row_serial.sv
// Directed self-checking bench for aes_inv_shift_row_serial (NUM_SHARES = 2).
module tb_aes_inv_shift_row_serial;
    import aes_pkg::*;

    typedef logic [15:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-derived InvShiftRows source index for output byte k
    int inv_exp [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    // FIPS-197 Appendix B, round 1: state after SubBytes and after ShiftRows
    logic [7:0] fips_sb [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                 8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    logic [7:0] fips_sr [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

    aes_inv_shift_row_serial #(.NUM_SHARES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drive 16 consecutive input bytes; returns #1 after the 16th transfer edge
    task automatic load_block(input blk_t blk);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = blk[k];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Drain with out_ready high, bounded; returns #1 after the last transfer edge
    task automatic drain_collect(output blk_t got, output logic [15:0] lastv, output int n);
        n = 0;
        lastv = '0;
        for (int k = 0; k < 16; k++) got[k] = '0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 16; cyc++) begin
            if (out_valid) begin
                got[n]   = out_data;
                lastv[n] = out_last;
                n++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_ordering();
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL order_load k=%0d in_ready=%b out_valid=%b exp 1/0", k, in_ready, out_valid);
            end
            in_valid = 1'b1;
            in_data  = {8'h00, 8'(k)};
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== {8'h00, 8'(inv_exp[k])} || out_last !== (k == 15) || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL order_out k=%0d valid=%b data=%h last=%b in_ready=%b exp 1/%h/%b/0",
                         k, out_valid, out_data, out_last, in_ready, {8'h00, 8'(inv_exp[k])}, (k == 15));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL order_end in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_masked();
        blk_t        blk, got;
        logic [15:0] lastv;
        int          n;
        for (int k = 0; k < 16; k++) blk[k] = {8'hA5 ^ 8'(k), 8'(k)};
        load_block(blk);
        drain_collect(got, lastv, n);
        n_checks++; if (n !== 16) begin n_fail++; $display("FAIL masked_count got=%0d exp=16", n); end
        n_checks++; if (lastv !== 16'h8000) begin n_fail++; $display("FAIL masked_last got=%h exp=8000", lastv); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (got[k][7:0] !== 8'(inv_exp[k])) begin
                n_fail++; $display("FAIL masked_share0 k=%0d got=%h exp=%h", k, got[k][7:0], 8'(inv_exp[k]));
            end
            n_checks++;
            if (got[k][15:8] !== (8'hA5 ^ 8'(inv_exp[k]))) begin
                n_fail++; $display("FAIL masked_share1 k=%0d got=%h exp=%h", k, got[k][15:8], 8'hA5 ^ 8'(inv_exp[k]));
            end
        end
    endtask

    task automatic test_round_trip();
        blk_t        blk, got;
        logic [15:0] lastv;
        int          n;
        for (int k = 0; k < 16; k++) blk[k] = {fips_sr[k] ^ 8'h3C, fips_sr[k]};
        load_block(blk);
        drain_collect(got, lastv, n);
        n_checks++; if (n !== 16) begin n_fail++; $display("FAIL fips_count got=%0d exp=16", n); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (got[k] !== {fips_sb[k] ^ 8'h3C, fips_sb[k]}) begin
                n_fail++; $display("FAIL fips_byte k=%0d got=%h exp=%h", k, got[k], {fips_sb[k] ^ 8'h3C, fips_sb[k]});
            end
        end
    endtask

    task automatic test_backpressure();
        blk_t        blk;
        int          idx = 0;
        int          cyc = 0;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_data = '0;
        logic        prev_last = 1'b0;
        for (int k = 0; k < 16; k++) blk[k] = {8'h5A ^ 8'(k * 7), 8'(8'h30 + 8'(k * 3))};
        load_block(blk);
        while (idx < 16 && cyc < 300) begin
            if (prev_stall) begin
                n_checks++;
                if (out_data !== prev_data || out_last !== prev_last) begin
                    n_fail++; $display("FAIL bp_stable cyc=%0d data=%h last=%b exp %h/%b", cyc, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
            end
            out_ready  = 1'($urandom_range(0, 1));
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = 16'($urandom);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== blk[inv_exp[idx]] || out_last !== (idx == 15)) begin
                    n_fail++; $display("FAIL bp_data k=%0d got=%h/%b exp=%h/%b", idx, out_data, out_last, blk[inv_exp[idx]], (idx == 15));
                end
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (idx !== 16) begin n_fail++; $display("FAIL bp_timeout got=%0d bytes exp=16", idx); end
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_end in_ready=%b busy=%b exp 1/0", in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        blk_t        a_in, b_in, b_pre;
        logic [15:0] got [32];
        int          ia = 0, ib = 0, nout = 0, cyc = 0;
        int          last_fire = -1, first_ready = -1;
        for (int k = 0; k < 16; k++) begin
            a_in[k]  = {8'h80 | 8'(k), 8'h10 + 8'(k)};
            b_pre[k] = {8'hC0 | 8'(k), 8'h40 + 8'(k)};
        end
        // Block B is the forward ShiftRows of b_pre, so it must come back as b_pre
        for (int k = 0; k < 16; k++) b_in[k] = b_pre[SR_IDX[k]];
        for (int k = 0; k < 32; k++) got[k] = '0;
        out_ready = 1'b1;
        while (nout < 32 && cyc < 120) begin
            if (in_ready && nout == 16 && first_ready < 0) first_ready = cyc;
            in_valid = 1'b1;
            in_data  = (ia < 16) ? a_in[ia] : b_in[(ib < 16) ? ib : 15];
            if (in_ready) begin
                if (ia < 16) ia++;
                else if (ib < 16) ib++;
            end
            if (out_valid) begin
                got[nout] = out_data;
                nout++;
                if (nout == 16) last_fire = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (nout !== 32) begin n_fail++; $display("FAIL b2b_timeout got=%0d bytes exp=32", nout); end
        n_checks++;
        if (first_ready !== last_fire + 1) begin
            n_fail++; $display("FAIL b2b_in_ready_cycle got=%0d exp=%0d", first_ready, last_fire + 1);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (got[k] !== a_in[inv_exp[k]]) begin
                n_fail++; $display("FAIL b2b_blockA k=%0d got=%h exp=%h", k, got[k], a_in[inv_exp[k]]);
            end
            n_checks++;
            if (got[16 + k] !== b_pre[k]) begin
                n_fail++; $display("FAIL b2b_blockB k=%0d got=%h exp=%h", k, got[16 + k], b_pre[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        blk_t        c_blk, d_blk, got;
        logic [15:0] lastv;
        int          n;
        for (int k = 0; k < 16; k++) begin
            c_blk[k] = {8'h11 * 8'(k), 8'hF0 - 8'(k)};
            d_blk[k] = {8'h77 ^ 8'(k), 8'h20 + 8'(k * 5)};
        end
        // Abandon a block during LOAD after 7 bytes
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 16'hDEAD + 16'(k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_load_busy got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0) begin
            n_fail++; $display("FAIL mid_load_rst in_ready=%b out_valid=%b busy=%b data=%h exp 1/0/0/0000", in_ready, out_valid, busy, out_data);
        end
        #1 rst = 1'b0;
        // Fresh block starts at k = 0; drain only 5 bytes, then abandon
        load_block(c_blk);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== c_blk[inv_exp[k]]) begin
                n_fail++; $display("FAIL mid_c_byte k=%0d valid=%b got=%h exp=%h", k, out_valid, out_data, c_blk[inv_exp[k]]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL mid_drain_rst in_ready=%b out_valid=%b busy=%b data=%h last=%b exp 1/0/0/0000/0",
                               in_ready, out_valid, busy, out_data, out_last);
        end
        #1 rst = 1'b0;
        load_block(d_blk);
        drain_collect(got, lastv, n);
        n_checks++; if (n !== 16) begin n_fail++; $display("FAIL mid_d_count got=%0d exp=16", n); end
        n_checks++; if (lastv !== 16'h8000) begin n_fail++; $display("FAIL mid_d_last got=%h exp=8000", lastv); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (got[k] !== d_blk[inv_exp[k]]) begin
                n_fail++; $display("FAIL mid_d_byte k=%0d got=%h exp=%h", k, got[k], d_blk[inv_exp[k]]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_masked();
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_shift_row_serial.md
Name: aes_inv_shift_row_serial

Overview:
- Byte-serial, share-parallel InvShiftRows stage for the masked AES decryption datapath.
- Accepts one 16-byte state per block, one byte (all shares) per cycle, in column-major order.
- Buffers the state, then emits it in InvShiftRows order over a valid/ready stream.
- InvShiftRows is linear, so every share gets the identical permutation. No randomness and no cross-share logic.

Parameters:
- NUM_SHARES, 2, number of Boolean shares carried per byte (1 = unmasked).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data holds a valid state byte.
- in_ready  output  1  block accepts a byte this cycle.
- in_data  input  8*NUM_SHARES  share s occupies bits [8*s+7:8*s].
- out_valid  output  1  out_data holds a valid output byte.
- out_ready  input  1  downstream accepts the byte this cycle.
- out_data  output  8*NUM_SHARES  same share layout as in_data.
- out_last  output  1  high with out_valid on the 16th output byte.
- busy  output  1  high whenever state != LOAD or the byte count != 0.

Behaviour:
- Byte index k = r + 4c (row r, column c, 0..3), the FIPS-197 column-major order. Used for both input and output.
- Transfer rule: a transfer occurs when valid && ready on a rising edge.
- Storage: buffer of 16 entries × 8*NUM_SHARES bits; 4-bit counter cnt; 1-bit state {LOAD, DRAIN}.
- Reset (async assert) values:
  - state = LOAD, cnt = 0, buffer cleared to all-zero (no stale shares).
  - in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, busy = 0.
- LOAD state:
  - in_ready = 1, out_valid = 0.
  - On each input transfer: buf[cnt] <= in_data, cnt <= cnt + 1.
  - On the transfer with cnt == 15: cnt <= 0, state <= DRAIN.
- DRAIN state:
  - in_ready = 0, out_valid = 1.
  - out_data = buf[r + 4*((c - r) mod 4)], where cnt = r + 4c. This is s'[r][c] = s[r][(c-r) mod 4].
  - out_last = (cnt == 15).
  - On each output transfer: cnt <= cnt + 1.
  - On the transfer with cnt == 15: cnt <= 0, state <= LOAD.
- Output path: out_data is driven from registered buffer contents through a mux. No combinational path from in_data to out_data.
- Latency: out_valid rises in the cycle after the 16th input transfer. in_ready rises in the cycle after the 16th output transfer.
- Throughput: 32 cycles per block with no backpressure. No LOAD/DRAIN overlap.
- Backpressure: with out_ready low in DRAIN, out_data, out_last and cnt hold stable. in_valid is ignored while in_ready = 0.
- Wrap-around: cnt wraps 15 -> 0 only at a state change. The buffer is not cleared between blocks; every entry is overwritten in LOAD.
- Reset mid-block (either state): immediately abandons the block. The next accepted byte is treated as k = 0.
- Share isolation: each share is muxed by its own slice with the same select. Never combine shares in any expression.

Decomposition:
- Shared package aes_pkg:
  - AES_STATE_BYTES = 16.
  - The 16-entry constant INV_SR_IDX = {0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3}, indexed by output k.
  - The matching SR_IDX table for the forward direction, for bench reuse.
  - Typedef of the share-vector byte.
- No sub-module. The index lookup is a package constant; the FSM, counter and buffer are small enough for one module.

Test Plan:
- Ordering: reset, then feed in_data byte k = 0x00..0x0F with out_ready = 1.
  - Output must be 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03.
  - out_last only on the 03 byte; first out_valid one cycle after the 0x0F transfer.
- Masked: NUM_SHARES = 2, share0 = k, share1 = 0xA5 ^ k.
  - share0 of the outputs matches the ordering sequence above; share1 of each output = 0xA5 ^ share0.
- Round trip: FIPS-197 Appendix B round-1 state after ShiftRows (d4,bf,5d,30,…) fed in.
  - Output equals the pre-ShiftRows state (d4,27,11,ae,…), bytewise for all shares.
- Backpressure: toggle out_ready pseudo-randomly.
  - out_data stable while out_valid && !out_ready.
  - in_ready = 0 throughout DRAIN; in_valid pulses there are dropped.
  - Sequence is unchanged.
- Back-to-back: two blocks with in_valid held high.
  - in_ready returns exactly one cycle after the first block's 16th output transfer.
  - Second block is correct and contains no bytes of the first.
- Reset mid-operation: assert rst after 7 inputs, and again after 5 outputs.
  - Outputs go to reset values asynchronously (out_valid = 0, out_data = 0, in_ready = 1, busy = 0).
  - The next full block is output correctly.
